// File: rtl/sdram_refresh_sched_pkg.sv
// Shared definitions for the SDRAM refresh scheduler: FSM states, SDRAM
// command encodings and the debug view exported by the top level.
package sdram_refresh_sched_pkg;

   typedef enum logic [3:0] {
      PWRUP    = 4'd0,
      PRECH    = 4'd1,
      WAIT_RP  = 4'd2,
      AREF     = 4'd3,
      WAIT_RFC = 4'd4,
      MRS      = 4'd5,
      WAIT_MRD = 4'd6,
      IDLE     = 4'd7,
      ACCESS   = 4'd8
   } state_t;

   // {RAS_n, CAS_n, WE_n}; chip selects are driven separately
   typedef struct packed {
      logic ras_n;
      logic cas_n;
      logic we_n;
   } cmd_t;

   localparam cmd_t CMD_NOP       = '{ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};
   localparam cmd_t CMD_PRECHARGE = '{ras_n: 1'b0, cas_n: 1'b1, we_n: 1'b0};
   localparam cmd_t CMD_REFRESH   = '{ras_n: 1'b0, cas_n: 1'b0, we_n: 1'b1};
   localparam cmd_t CMD_MRS       = '{ras_n: 1'b0, cas_n: 1'b0, we_n: 1'b0};

   localparam int MA_AP_BIT = 10;

   typedef struct packed {
      state_t     state;
      logic [2:0] pending;
   } dbg_t;

endpackage

// File: rtl/sdram_refresh_sched_refresh_timer.sv
// Refresh interval timer with a saturating count of owed auto-refreshes.
module refresh_timer #(
   parameter int REF_INTERVAL = 195
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       aref_i,
   output logic [2:0] pending_o
);

   localparam int TW = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;

   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    pending_q, pending_d;
   logic          wrap;

   assign wrap = en_i && (timer_q == TW'(REF_INTERVAL - 1));

   always_comb begin
      timer_d   = timer_q;
      pending_d = pending_q;
      if (en_i) begin
         timer_d = wrap ? '0 : timer_q + 1'b1;
      end
      // A wrap and an issued refresh in the same cycle cancel out
      case ({wrap, aref_i})
         2'b10: if (pending_q != 3'd7) pending_d = pending_q + 3'd1;
         2'b01: if (pending_q != 3'd0) pending_d = pending_q - 3'd1;
         default: pending_d = pending_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timer_q   <= '0;
         pending_q <= '0;
      end else begin
         timer_q   <= timer_d;
         pending_q <= pending_d;
      end
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/sdram_refresh_sched.sv
// SDRAM power-up/init sequencer and auto-refresh scheduler that arbitrates
// the SDRAM pins between refresh and the Zorro III RAM access path.
module sdram_refresh_sched
   import sdram_refresh_sched_pkg::*;
#(
   parameter int          T_PWRUP      = 5000,
   parameter int          REF_INTERVAL = 195,
   parameter int          T_RP         = 2,
   parameter int          T_RFC        = 4,
   parameter int          T_MRD        = 2,
   parameter logic [12:0] MODE_REG     = 13'h020
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ram_cycle,
   output logic        access_grant,
   output logic        own_bus,
   output logic        init_done,
   output logic        CKE,
   output logic [1:0]  CS_n,
   output logic        RAS_n,
   output logic        CAS_n,
   output logic        WE_n,
   output logic [1:0]  BA,
   output logic [12:0] MA,
   output dbg_t        dbg_o
);

   localparam int CW = $clog2(T_PWRUP + T_RP + T_RFC + T_MRD + 1);

   state_t      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]  aref_n_q, aref_n_d;
   logic        init_done_q, init_done_d;
   logic [2:0]  pending;
   logic        aref_post_init;

   logic        cke_q, cke_d;
   logic [1:0]  cs_n_q, cs_n_d;
   cmd_t        cmd_q, cmd_d;
   logic [1:0]  ba_q, ba_d;
   logic [12:0] ma_q, ma_d;
   logic        grant_q, grant_d;
   logic        own_q, own_d;

   assign aref_post_init = (state_q == AREF) && init_done_q;

   refresh_timer #(
      .REF_INTERVAL(REF_INTERVAL)
   ) u_refresh_timer (
      .clk_i    (CLK),
      .rst_i    (RESET),
      .en_i     (init_done_q),
      .aref_i   (aref_post_init),
      .pending_o(pending)
   );

   always_comb begin
      state_d     = state_q;
      aref_n_d    = aref_n_q;
      init_done_d = init_done_q;
      case (state_q)
         PWRUP:    if (cnt_q == CW'(T_PWRUP - 1)) state_d = PRECH;
         PRECH:    state_d = WAIT_RP;
         WAIT_RP:  if (cnt_q == CW'(T_RP - 1)) state_d = AREF;
         AREF: begin
            state_d = WAIT_RFC;
            if (!init_done_q) aref_n_d = aref_n_q + 2'd1;
         end
         // Init runs two refreshes back to back, then programs the mode register
         WAIT_RFC: if (cnt_q == CW'(T_RFC - 1)) begin
            if (init_done_q)            state_d = IDLE;
            else if (aref_n_q == 2'd2)  state_d = MRS;
            else                        state_d = AREF;
         end
         MRS:      state_d = WAIT_MRD;
         WAIT_MRD: if (cnt_q == CW'(T_MRD - 1)) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
         end
         IDLE: begin
            if (pending != 3'd0) state_d = PRECH;
            else if (ram_cycle)  state_d = ACCESS;
         end
         ACCESS:   if (!ram_cycle) state_d = IDLE;
         default:  state_d = PWRUP;
      endcase

      cnt_d = cnt_q + 1'b1;
      if ((state_d != state_q) || (state_d == IDLE) || (state_d == ACCESS)) begin
         cnt_d = '0;
      end
   end

   // Pin values are decoded from the next state so they line up with state_q
   always_comb begin
      cmd_d   = CMD_NOP;
      ma_d    = '0;
      ba_d    = '0;
      cs_n_d  = 2'b00;
      cke_d   = (state_d != PWRUP);
      grant_d = (state_d == ACCESS);
      own_d   = (state_d != ACCESS);
      case (state_d)
         PRECH: begin
            cmd_d           = CMD_PRECHARGE;
            ma_d[MA_AP_BIT] = 1'b1;
         end
         AREF:    cmd_d = CMD_REFRESH;
         MRS: begin
            cmd_d = CMD_MRS;
            ma_d  = MODE_REG;
         end
         default: cmd_d = CMD_NOP;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= PWRUP;
         cnt_q       <= '0;
         aref_n_q    <= '0;
         init_done_q <= 1'b0;
         cke_q       <= 1'b0;
         cs_n_q      <= 2'b11;
         cmd_q       <= CMD_NOP;
         ba_q        <= '0;
         ma_q        <= '0;
         grant_q     <= 1'b0;
         own_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         aref_n_q    <= aref_n_d;
         init_done_q <= init_done_d;
         cke_q       <= cke_d;
         cs_n_q      <= cs_n_d;
         cmd_q       <= cmd_d;
         ba_q        <= ba_d;
         ma_q        <= ma_d;
         grant_q     <= grant_d;
         own_q       <= own_d;
      end
   end

   assign access_grant  = grant_q;
   assign own_bus       = own_q;
   assign init_done     = init_done_q;
   assign CKE           = cke_q;
   assign CS_n          = cs_n_q;
   assign RAS_n         = cmd_q.ras_n;
   assign CAS_n         = cmd_q.cas_n;
   assign WE_n          = cmd_q.we_n;
   assign BA            = ba_q;
   assign MA            = ma_q;
   assign dbg_o.state   = state_q;
   assign dbg_o.pending = pending;

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// Directed bench for sdram_refresh_sched with T_PWRUP=8, REF_INTERVAL=20.
module tb_sdram_refresh_sched;
   import sdram_refresh_sched_pkg::*;

   localparam logic [4:0] C_NOP = 5'b00111;
   localparam logic [4:0] C_PRE = 5'b00010;
   localparam logic [4:0] C_REF = 5'b00001;
   localparam logic [4:0] C_MRS = 5'b00000;
   localparam logic [4:0] C_DES = 5'b11111;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        ram_cycle;
   logic        access_grant, own_bus, init_done, CKE;
   logic [1:0]  CS_n;
   logic        RAS_n, CAS_n, WE_n;
   logic [1:0]  BA;
   logic [12:0] MA;
   dbg_t        dbg;
   logic [4:0]  cmd;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int base     = 0;
   int aref_seen = 0;
   logic exp_grant;
   int pre_at[$];
   int ref_at[$];

   assign cmd = {CS_n, RAS_n, CAS_n, WE_n};

   sdram_refresh_sched #(
      .T_PWRUP     (8),
      .REF_INTERVAL(20),
      .T_RP        (2),
      .T_RFC       (4),
      .T_MRD       (2),
      .MODE_REG    (13'h020)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .ram_cycle   (ram_cycle),
      .access_grant(access_grant),
      .own_bus     (own_bus),
      .init_done   (init_done),
      .CKE         (CKE),
      .CS_n        (CS_n),
      .RAS_n       (RAS_n),
      .CAS_n       (CAS_n),
      .WE_n        (WE_n),
      .BA          (BA),
      .MA          (MA),
      .dbg_o       (dbg)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc - base);
      end
   endtask

   function automatic bit is_pre(input int r);
      foreach (pre_at[i]) if (pre_at[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit is_ref(input int r);
      foreach (ref_at[i]) if (ref_at[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_reset_vals();
      chk("rst_cke",   32'(CKE), 0);
      chk("rst_cmd",   32'(cmd), 32'(C_DES));
      chk("rst_ba",    32'(BA), 0);
      chk("rst_ma",    32'(MA), 0);
      chk("rst_own",   32'(own_bus), 1);
      chk("rst_grant", 32'(access_grant), 0);
      chk("rst_init",  32'(init_done), 0);
      chk("rst_pend",  32'(dbg.pending), 0);
      chk("rst_state", 32'(dbg.state), 32'(PWRUP));
   endtask

   // Init: NOP with CKE=0 for 8 cycles, PRE at 8, AREF at 11 and 16, MRS at 21,
   // init_done at 24. Grant must stay low regardless of ram_cycle.
   task automatic run_init();
      logic [4:0] e;
      for (int k = 1; k <= 24; k++) begin
         tick();
         e = C_NOP;
         if (k == 8) e = C_PRE;
         if (k == 11 || k == 16) e = C_REF;
         if (k == 21) e = C_MRS;
         chk("init_cmd",   32'(cmd), 32'(e));
         chk("init_cke",   32'(CKE), (k >= 8) ? 1 : 0);
         chk("init_done",  32'(init_done), (k == 24) ? 1 : 0);
         chk("init_grant", 32'(access_grant), 0);
         chk("init_own",   32'(own_bus), 1);
         if (k == 8) chk("init_pre_ma10", 32'(MA[10]), 1);
         if (k == 21) begin
            chk("init_mrs_ma", 32'(MA), 32'h020);
            chk("init_mrs_ba", 32'(BA), 0);
         end
      end
      base = cyc;
   endtask

   // driver: advance to a cycle offset from init_done, checking every cycle
   task automatic run_to(input int target);
      logic [4:0] e;
      int r;
      while ((cyc - base) < target) begin
         tick();
         r = cyc - base;
         e = is_pre(r) ? C_PRE : (is_ref(r) ? C_REF : C_NOP);
         chk("run_cmd",   32'(cmd), 32'(e));
         chk("run_grant", 32'(access_grant), 32'(exp_grant));
         chk("run_own",   32'(own_bus), 32'(!exp_grant));
         chk("run_cke",   32'(CKE), 1);
         if (e == C_PRE) chk("run_pre_ma10", 32'(MA[10]), 1);
         if (cmd == C_REF) aref_seen++;
      end
   endtask

   initial begin
      pre_at = '{21, 41, 83, 92, 101, 121};
      ref_at = '{24, 44, 86, 95, 104, 124};
      for (int k = 0; k < 8; k++) begin
         pre_at.push_back(333 + 9 * k);
         ref_at.push_back(336 + 9 * k);
      end

      RESET     = 1'b1;
      ram_cycle = 1'b0;
      exp_grant = 1'b0;
      tick(); tick(); tick();
      check_reset_vals();
      RESET = 1'b0;
      run_init();
      chk("idle_state", 32'(dbg.state), 32'(IDLE));

      // idle refresh every 20 cycles
      run_to(20);
      chk("wrap1_pend", 32'(dbg.pending), 1);
      run_to(25);
      chk("aref1_pend", 32'(dbg.pending), 0);
      run_to(49);
      chk("idle2_state", 32'(dbg.state), 32'(IDLE));

      // long access across two timer wraps, then two back-to-back refreshes
      ram_cycle = 1'b1;
      exp_grant = 1'b1;
      run_to(60);
      chk("acc_pend60", 32'(dbg.pending), 1);
      run_to(81);
      chk("acc_pend81", 32'(dbg.pending), 2);
      ram_cycle = 1'b0;
      exp_grant = 1'b0;
      run_to(82);
      chk("rel_state", 32'(dbg.state), 32'(IDLE));
      chk("rel_pend",  32'(dbg.pending), 2);
      run_to(91);
      chk("b2b_pend91", 32'(dbg.pending), 1);
      run_to(99);
      chk("b2b_pend99", 32'(dbg.pending), 0);
      run_to(100);
      chk("b2b_idle", 32'(dbg.state), 32'(IDLE));
      chk("wrap100_pend", 32'(dbg.pending), 1);
      run_to(120);
      chk("wrap120_pend", 32'(dbg.pending), 1);

      // ram_cycle rises as pending becomes 1: refresh first, grant 9 cycles later
      ram_cycle = 1'b1;
      run_to(129);
      exp_grant = 1'b1;
      run_to(130);
      ram_cycle = 1'b0;
      exp_grant = 1'b0;
      run_to(131);
      chk("prio_state", 32'(dbg.state), 32'(IDLE));
      chk("prio_pend",  32'(dbg.pending), 0);

      // 200-cycle access: ten wraps saturate pending at 7
      ram_cycle = 1'b1;
      exp_grant = 1'b1;
      run_to(321);
      chk("sat_pend321", 32'(dbg.pending), 7);
      run_to(331);
      chk("sat_pend331", 32'(dbg.pending), 7);
      ram_cycle = 1'b0;
      exp_grant = 1'b0;
      run_to(332);
      chk("sat_pend332", 32'(dbg.pending), 7);
      aref_seen = 0;
      run_to(395);
      chk("sat_arefs", 32'(aref_seen), 7);
      run_to(400);
      chk("pre_rst_state", 32'(dbg.state), 32'(WAIT_RFC));

      // reset during WAIT_RFC; ram_cycle held through the new init
      RESET     = 1'b1;
      ram_cycle = 1'b1;
      tick();
      check_reset_vals();
      RESET = 1'b0;
      run_init();
      tick();
      chk("post_init_grant", 32'(access_grant), 1);
      chk("post_init_own",   32'(own_bus), 0);
      ram_cycle = 1'b0;
      tick();
      chk("post_rel_grant", 32'(access_grant), 0);
      chk("post_rel_own",   32'(own_bus), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
